slt_flag_engine: RTL and testbench

Multi-cycle, parametrised set-flag unit for the wide ALU. Compares two WIDTH-bit operands one CHUNK-bit slice per cycle, starting at the most significant slice, and stops early at the first differing slice. Supports signed/unsigned less-than, equal and not-equal selection, plus a mode override. Uses valid/ready handshakes on both sides and sits between the operand register stage and the ALU result mux.

---
 rtl/slt_flag_engine.sv | 179 +++++++++++++++++
 tb/tb_slt_flag_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slt_flag_engine.sv
// -----------------------------------------------------------------------------
// slt_flag_engine
// Multi-cycle set-flag unit for the wide ALU. Compares two WIDTH-bit operands
// one CHUNK-bit slice per cycle, most significant slice first, and finishes at
// the first slice that differs. Produces signed/unsigned less-than, equality
// and the selected flag (SLT / SLTU / EQ / NE). An arithmetic-mode request
// skips the compare and returns all-zero flags.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous, active-low reset
//   in_valid   - request valid (op1, op2, cmp_op, mode)
//   in_ready   - engine idle and able to accept a request
//   op1, op2   - operands A and B
//   cmp_op     - 00 SLT, 01 SLTU, 10 EQ, 11 NE
//   mode       - 1: arithmetic mode, flags forced to 0
//   out_valid  - result valid (held until out_ready)
//   out_ready  - consumer accepts the result
//   s_flag     - selected flag
//   lt, eq     - raw less-than / equality of the last result
//   busy       - request in flight (compare or waiting to be consumed)
// -----------------------------------------------------------------------------
module slt_flag_engine #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       cmp_op,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s_flag,
    output logic             lt,
    output logic             eq,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_mode;
    logic [IDXW-1:0]  r_idx;
    logic             r_lt;
    logic             r_eq;
    logic             r_s_flag;

    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;
    logic             w_top;
    logic             w_signed;
    logic             w_diff;
    logic             w_lt;
    logic             w_last;

    // Map raw lt/eq onto the selected flag; arithmetic mode always yields 0.
    function automatic logic sel_flag(input logic [1:0] op, input logic md,
                                      input logic l, input logic e);
        logic f;
        if (md) begin
            f = 1'b0;
        end else begin
            case (op)
                2'b00:   f = l;
                2'b01:   f = l;
                2'b10:   f = e;
                2'b11:   f = ~e;
                default: f = 1'b0;
            endcase
        end
        return f;
    endfunction

    // Current slice of each captured operand, selected by the slice index.
    assign w_sa = CHUNK'(r_a >> (r_idx * CHUNK));
    assign w_sb = CHUNK'(r_b >> (r_idx * CHUNK));

    assign w_top    = (r_idx == IDXW'(NCHUNK - 1));
    assign w_last   = (r_idx == IDXW'(0));
    assign w_signed = w_top && (r_op == 2'b00);
    assign w_diff   = (w_sa != w_sb);

    // Slice less-than: only the top slice of a signed compare looks at the
    // sign bits; lower slices are plain magnitude comparisons.
    always_comb begin
        w_lt = 1'b0;
        if (w_signed && (w_sa[CHUNK-1] != w_sb[CHUNK-1])) begin
            w_lt = w_sa[CHUNK-1];
        end else begin
            w_lt = (w_sa < w_sb);
        end
    end

    // Control FSM, operand capture and registered result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 2'b00;
            r_mode   <= 1'b0;
            r_idx    <= '0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_s_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a    <= op1;
                        r_b    <= op2;
                        r_op   <= cmp_op;
                        r_mode <= mode;
                        r_idx  <= IDXW'(NCHUNK - 1);
                        if (mode) begin
                            r_lt     <= 1'b0;
                            r_eq     <= 1'b0;
                            r_s_flag <= 1'b0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_CMP;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    if (w_diff) begin
                        r_lt     <= w_lt;
                        r_eq     <= 1'b0;
                        r_s_flag <= sel_flag(r_op, r_mode, w_lt, 1'b0);
                        r_state  <= ST_DONE;
                    end else if (w_last) begin
                        r_lt     <= 1'b0;
                        r_eq     <= 1'b1;
                        r_s_flag <= sel_flag(r_op, r_mode, 1'b0, 1'b1);
                        r_state  <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx - IDXW'(1);
                        r_state <= ST_CMP;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    assign in_ready  = rst_n && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_CMP) || (r_state == ST_DONE);
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign s_flag    = r_s_flag;

endmodule

// File: tb/tb_slt_flag_engine.sv
// -----------------------------------------------------------------------------
// Testbench for slt_flag_engine (WIDTH=128, CHUNK=32). A transaction-level
// model predicts the flags from whole-operand arithmetic and the latency from
// the position of the most significant differing slice; a negedge process
// compares every output against it each cycle. Directed transactions also
// pin hand-computed latencies and flag values.
// -----------------------------------------------------------------------------
module tb_slt_flag_engine;

    localparam int WIDTH  = 128;
    localparam int CHUNK  = 32;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] op1 = '0;
    logic [WIDTH-1:0] op2 = '0;
    logic [1:0]       cmp_op = 2'b00;
    logic             mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             s_flag;
    logic             lt;
    logic             eq;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    slt_flag_engine #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .cmp_op(cmp_op), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .s_flag(s_flag), .lt(lt), .eq(eq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of one request from whole-operand arithmetic.
    function automatic void predict(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [1:0] op, input logic md,
                                    output int lat, output logic l, output logic e,
                                    output logic s);
        logic [WIDTH-1:0] x;
        if (md) begin
            lat = 0; l = 1'b0; e = 1'b0; s = 1'b0;
        end else begin
            e = (a == b);
            l = (op == 2'b00) ? ($signed(a) < $signed(b)) : (a < b);
            case (op)
                2'b00, 2'b01: s = l;
                2'b10:        s = e;
                default:      s = ~e;
            endcase
            // Latency: edges until the most significant differing slice is seen.
            x   = a ^ b;
            lat = NCHUNK;
            for (int k = NCHUNK - 1; k >= 0; k--) begin
                if (((x >> (k * CHUNK)) & {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}}) != '0) begin
                    lat = NCHUNK - k;
                    break;
                end
            end
        end
    endfunction

    // Reference model state (transaction level).
    logic m_pending = 1'b0;
    logic m_valid   = 1'b0;
    int   m_cnt     = 0;
    logic m_lt = 1'b0, m_eq = 1'b0, m_s = 1'b0;
    logic p_lt, p_eq, p_s;

    // Advance the model on each rising edge using the inputs held across it.
    always @(posedge clk) begin
        int lat;
        if (!rst_n) begin
            m_pending = 1'b0; m_valid = 1'b0; m_cnt = 0;
            m_lt = 1'b0; m_eq = 1'b0; m_s = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_pending) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_pending = 1'b0; m_valid = 1'b1;
                m_lt = p_lt; m_eq = p_eq; m_s = p_s;
            end
        end else if (in_valid) begin
            predict(op1, op2, cmp_op, mode, lat, p_lt, p_eq, p_s);
            if (lat == 0) begin
                m_valid = 1'b1;
                m_lt = p_lt; m_eq = p_eq; m_s = p_s;
            end else begin
                m_pending = 1'b1; m_cnt = lat;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("out_valid", int'(out_valid), int'(m_valid));
        check("in_ready",  int'(in_ready),  int'(rst_n && !m_pending && !m_valid));
        check("busy",      int'(busy),      int'(m_pending || m_valid));
        check("s_flag",    int'(s_flag),    int'(m_s));
        check("lt",        int'(lt),        int'(m_lt));
        check("eq",        int'(eq),        int'(m_eq));
    end

    // One request: wait for accept, measure latency, hold backpressure, consume.
    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [1:0] op, input logic md, input int hold,
                           input bit lit, input int e_lat, input logic e_s,
                           input logic e_lt, input logic e_eq);
        bit acc = 0;
        int n = 0;
        int tries = 0;
        op1 = a; op2 = b; cmp_op = op; mode = md;
        in_valid = 1'b1; out_ready = 1'b0;
        while (!acc && tries < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            tries++;
        end
        check("accepted", int'(acc), 1);
        // Junk request held high while busy must be ignored.
        in_valid = 1'b1;
        op1 = {$urandom, $urandom, $urandom, $urandom};
        op2 = {$urandom, $urandom, $urandom, $urandom};
        cmp_op = 2'($urandom_range(3)); mode = 1'($urandom_range(1));
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("resp_seen", int'(out_valid), 1);
        if (lit) begin
            check("latency", n, e_lat);
            check("lit_s_flag", int'(s_flag), int'(e_s));
            check("lit_lt", int'(lt), int'(e_lt));
            check("lit_eq", int'(eq), int'(e_eq));
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("consumed_no_accept", int'(in_ready), 1);
    endtask

    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] BEEF    = {NCHUNK{32'hDEAD_BEEF}};

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int hold_seen;
        // 1. Reset with in_valid asserted.
        rst_n = 1'b0; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_s_flag", int'(s_flag), 0);
        in_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // 2. Signed vs unsigned, decided in the top slice.
        run_txn(NEG_MIN, 128'd1, 2'b00, 1'b0, 0, 1, 1, 1'b1, 1'b1, 1'b0);
        run_txn(NEG_MIN, 128'd1, 2'b01, 1'b0, 0, 1, 1, 1'b0, 1'b0, 1'b0);
        // 3. Equal operands, full scan.
        run_txn(BEEF, BEEF, 2'b10, 1'b0, 0, 1, NCHUNK, 1'b1, 1'b0, 1'b1);
        run_txn(BEEF, BEEF, 2'b11, 1'b0, 0, 1, NCHUNK, 1'b0, 1'b0, 1'b1);
        // 4. Difference only in the lowest slice.
        run_txn(128'd5, 128'd6, 2'b01, 1'b0, 0, 1, NCHUNK, 1'b1, 1'b1, 1'b0);
        run_txn(128'd6, 128'd5, 2'b01, 1'b0, 0, 1, NCHUNK, 1'b0, 1'b0, 1'b0);
        // Difference in slice 2 of a signed compare: latency 2.
        run_txn({32'h1, 32'h5, 64'h0}, {32'h1, 32'h7, 64'h0}, 2'b00, 1'b0, 0, 1, 2,
                1'b1, 1'b1, 1'b0);
        // 5. Mode override.
        run_txn(128'd0, {WIDTH{1'b1}}, 2'b01, 1'b1, 0, 1, 0, 1'b0, 1'b0, 1'b0);

        // 6a. Backpressure: result held 5 cycles, new request waits.
        run_txn(128'd3, 128'd9, 2'b01, 1'b0, 5, 1, NCHUNK, 1'b1, 1'b1, 1'b0);
        op1 = 128'd1; op2 = 128'd2; cmp_op = 2'b01; mode = 1'b0; in_valid = 1'b1;
        out_ready = 1'b0;
        hold_seen = 0;
        while (!out_valid && hold_seen < 20) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            hold_seen++;
        end
        check("bp_resp", int'(out_valid), 1);
        repeat (5) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            check("bp_stable_valid", int'(out_valid), 1);
            check("bp_stable_s", int'(s_flag), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_no_same_edge_accept", int'(busy), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accept_next", int'(busy), 1);
        hold_seen = 0;
        while (!out_valid && hold_seen < 20) begin
            @(posedge clk); #1;
            hold_seen++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // 6b. Reset during compare abandons the request.
        op1 = 128'd5; op2 = 128'd5; cmp_op = 2'b10; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) hold_seen++;
        end
        check("mid_rst_no_result", hold_seen, 0);

        // Random phase: operands share random upper slices to vary latency.
        for (int t = 0; t < 60; t++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = ra;
            for (int k = 0; k < NCHUNK; k++) begin
                if ($urandom_range(2) == 0) rb[k*CHUNK +: CHUNK] = $urandom;
            end
            if ($urandom_range(3) == 0) rb[WIDTH-1] = ~rb[WIDTH-1];
            repeat ($urandom_range(2)) begin
                @(posedge clk); #1;
            end
            run_txn(ra, rb, 2'($urandom_range(3)), ($urandom_range(7) == 0),
                    $urandom_range(3), 0, 0, 1'b0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
